// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image/window geometry and the KxK window packing used by simpleCNN.
package cnn_pkg;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K = 5;
  localparam int PW = 8;
  localparam int CW = 5;
  localparam int WW = K * K * PW;
  typedef logic [PW-1:0] pix_t;
  function automatic int win_idx(input int k, input int l);
    return k * K + l;
  endfunction
endpackage

// File: rtl/cnn_window_gen_if.sv
// cnn_window_gen_if: pixel-in and window-out handshakes of the window generator.
interface cnn_window_gen_if;
  import cnn_pkg::*;
  logic PIX_VALID;
  logic PIX_READY;
  pix_t PIX_DATA;
  logic WIN_VALID;
  logic WIN_READY;
  logic [WW-1:0] WIN;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic FRAME_DONE;
  modport master(output PIX_VALID, PIX_DATA, WIN_READY,
                 input PIX_READY, WIN_VALID, WIN, X, Y, FRAME_DONE);
  modport slave(input PIX_VALID, PIX_DATA, WIN_READY,
                output PIX_READY, WIN_VALID, WIN, X, Y, FRAME_DONE);
endinterface

// File: rtl/cnn_line_buffer.sv
// cnn_line_buffer: one image row of delay; dout is the pixel written DEPTH enables ago.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = IMG_W,
  parameter int W = PW
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  assign dout = mem[ptr];
  always_ff @(posedge CLK)
    if (en) mem[ptr] <= din;
  always_ff @(posedge CLK or posedge RST)
    if (RST) ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: builds every KxK window of a raster pixel stream using K-1 line buffers.
module cnn_window_gen
  import cnn_pkg::*;
(
  input logic CLK,
  input logic RST,
  cnn_window_gen_if.slave b
);
  logic en;
  logic acc;
  logic emit;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [WW-1:0] win;
  pix_t tap [K];
  pix_t sr [K][K];
  assign b.PIX_READY = en && (!b.WIN_VALID || b.WIN_READY);
  assign acc = b.PIX_VALID && b.PIX_READY;
  assign emit = acc && row >= CW'(K - 1) && col >= CW'(K - 1);
  assign tap[0] = b.PIX_DATA;
  // tap[j] is the pixel j rows above the incoming one, same column
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    cnn_line_buffer lb (.CLK(CLK), .RST(RST), .en(acc), .din(tap[i]), .dout(tap[i+1]));
  end
  for (genvar k = 0; k < K; k++) begin : g_row
    for (genvar l = 0; l < K; l++) begin : g_col
      assign win[win_idx(k, l)*PW +: PW] = sr[k][l];
    end
  end
  assign b.WIN = win;
  // the shift register only moves on accept, so it doubles as the held output window
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      en <= 1'b0;
      col <= '0;
      row <= '0;
      sr <= '{default: '0};
      b.WIN_VALID <= 1'b0;
      b.X <= '0;
      b.Y <= '0;
      b.FRAME_DONE <= 1'b0;
    end else begin
      en <= 1'b1;
      b.FRAME_DONE <= b.WIN_VALID && b.WIN_READY &&
                      b.X == CW'(IMG_W - K) && b.Y == CW'(IMG_H - K);
      b.WIN_VALID <= emit || (b.WIN_VALID && !b.WIN_READY);
      if (emit) begin
        b.X <= col - CW'(K - 1);
        b.Y <= row - CW'(K - 1);
      end
      if (acc) begin
        col <= (col == CW'(IMG_W - 1)) ? '0 : col + 1'b1;
        if (col == CW'(IMG_W - 1)) row <= (row == CW'(IMG_H - 1)) ? '0 : row + 1'b1;
        for (int k = 0; k < K; k++) begin
          for (int l = 0; l < K - 1; l++) sr[k][l] <= sr[k][l+1];
          sr[k][K-1] <= tap[K-1-k];
        end
      end
    end
endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: scoreboard bench; expected windows come from a whole-frame image model.
module tb_cnn_window_gen;
  import cnn_pkg::*;
  typedef struct {
    int x;
    int y;
    logic [WW-1:0] w;
  } win_t;
  logic CLK = 0;
  logic RST = 1;
  always #5 CLK = ~CLK;
  cnn_window_gen_if b ();
  cnn_window_gen dut (.CLK(CLK), .RST(RST), .b(b));
  win_t q[$];
  win_t e;
  int total = 0;
  int bad = 0;
  int fd_seen = 0;
  int fd0;
  bit fd_exp = 0;
  bit rmode = 0;
  bit armed = 0;
  bit stalling = 0;
  int ax = 0, ay = 0, alen = 0, stall_left = 0;
  logic [WW-1:0] hw;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input bit cst);
    logic [PW-1:0] img [IMG_H][IMG_W];
    win_t w;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = cst ? 8'hAA : PW'(r * IMG_W + c);
    for (int y = 0; y <= IMG_H - K; y++)
      for (int x = 0; x <= IMG_W - K; x++) begin
        w.x = x;
        w.y = y;
        w.w = '0;
        for (int k = 0; k < K; k++)
          for (int l = 0; l < K; l++) w.w[(k*K+l)*PW +: PW] = img[y+k][x+l];
        q.push_back(w);
      end
  endtask

  task automatic send_pix(input logic [PW-1:0] d, input int gap);
    int t;
    t = 0;
    while (int'($urandom_range(99)) < gap) begin
      b.PIX_VALID = 0;
      @(posedge CLK);
      #1;
    end
    b.PIX_VALID = 1;
    b.PIX_DATA = d;
    forever begin
      @(negedge CLK);
      if (b.PIX_READY) break;
      t++;
      if (t > 5000) begin
        $display("FAIL pix_timeout actual=stuck required=accept");
        $fatal(1);
      end
    end
    @(posedge CLK);
    #1;
    b.PIX_VALID = 0;
  endtask

  task automatic send_frame(input bit cst, input int gap, input int npix);
    for (int i = 0; i < npix; i++) send_pix(cst ? 8'hAA : PW'(i), gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(posedge CLK);
      t++;
    end
    chk("drain_left", q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // window-ready driver with an optional targeted stall
  initial begin
    b.WIN_READY = 0;
    forever begin
      @(posedge CLK);
      #1;
      stalling = 0;
      if (stall_left > 0) begin
        stall_left--;
        stalling = 1;
        b.WIN_READY = 0;
      end else if (armed && b.WIN_VALID && b.X == CW'(ax) && b.Y == CW'(ay)) begin
        armed = 0;
        stall_left = alen - 1;
        stalling = 1;
        hw = b.WIN;
        b.WIN_READY = 0;
      end else b.WIN_READY = rmode ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // monitor: pops the scoreboard on every window transfer
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        fd_exp = 0;
        continue;
      end
      chk("frame_done", b.FRAME_DONE, fd_exp);
      if (b.FRAME_DONE) fd_seen++;
      fd_exp = 0;
      if (stalling) begin
        chk("stall_win", b.WIN, hw);
        chk("stall_x", b.X, ax);
        chk("stall_y", b.Y, ay);
        chk("stall_pix_ready", b.PIX_READY, 0);
      end
      if (b.WIN_VALID && b.WIN_READY) begin
        if (q.size() == 0) chk("unexpected_window", 1, 0);
        else begin
          e = q.pop_front();
          chk("win_x", b.X, e.x);
          chk("win_y", b.Y, e.y);
          chk("win_data", b.WIN, e.w);
          if (e.x == IMG_W - K && e.y == IMG_H - K) fd_exp = 1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    b.PIX_VALID = 0;
    b.PIX_DATA = 0;
    #3;
    chk("rst_pix_ready", b.PIX_READY, 0);
    chk("rst_win_valid", b.WIN_VALID, 0);
    chk("rst_win", b.WIN, 0);
    chk("rst_x", b.X, 0);
    chk("rst_y", b.Y, 0);
    chk("rst_frame_done", b.FRAME_DONE, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 0;
    fd0 = fd_seen;
    push_frame(0);
    send_frame(0, 0, IMG_W * IMG_H);
    drain();
    chk("t1_frame_done_count", fd_seen - fd0, 1);
    ax = 5; ay = 7; alen = 10; armed = 1;
    fd0 = fd_seen;
    push_frame(0);
    send_frame(0, 0, IMG_W * IMG_H);
    drain();
    chk("t2_stall_hit", armed, 0);
    chk("t2_frame_done_count", fd_seen - fd0, 1);
    rmode = 1;
    fd0 = fd_seen;
    push_frame(0);
    send_frame(0, 50, IMG_W * IMG_H);
    drain();
    rmode = 0;
    chk("t3_frame_done_count", fd_seen - fd0, 1);
    fd0 = fd_seen;
    push_frame(0);
    push_frame(1);
    send_frame(0, 0, IMG_W * IMG_H);
    send_frame(1, 0, IMG_W * IMG_H);
    drain();
    chk("t4_frame_done_count", fd_seen - fd0, 2);
    push_frame(0);
    send_frame(0, 0, 300);
    RST = 1;
    #1;
    chk("t5_pix_ready", b.PIX_READY, 0);
    chk("t5_win_valid", b.WIN_VALID, 0);
    chk("t5_win", b.WIN, 0);
    chk("t5_x", b.X, 0);
    chk("t5_y", b.Y, 0);
    chk("t5_frame_done", b.FRAME_DONE, 0);
    q.delete();
    @(posedge CLK);
    #1;
    RST = 0;
    fd0 = fd_seen;
    push_frame(0);
    send_frame(0, 0, IMG_W * IMG_H);
    drain();
    chk("t5_frame_done_count", fd_seen - fd0, 1);
    ax = IMG_W - K; ay = IMG_H - K; alen = 5; armed = 1;
    fd0 = fd_seen;
    push_frame(0);
    send_frame(0, 0, IMG_W * IMG_H);
    drain();
    chk("t6_stall_hit", armed, 0);
    chk("t6_frame_done_count", fd_seen - fd0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
